// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction fetch queue sitting between the IROM fetch port and the ID stage.
// It is a DEPTH-entry circular FIFO with valid/ready handshakes on both sides.
// A branch/jump redirect (flush_i) discards everything held in the queue. With
// FALLTHROUGH=1 an entry offered to an empty queue is presented on the
// dequeue side in the same cycle, and it bypasses storage when ID takes it.
//
// Parameters:
//   XLEN        - PC width in bits
//   ILEN        - instruction word width in bits
//   DEPTH       - number of entries (power of two, >= 2)
//   FALLTHROUGH - 1: same-cycle pass-through when empty, 0: registered only
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   flush_i      in   redirect; discards all contents and in-flight handshakes
//   enq_valid_i  in   fetch side offers an entry
//   enq_ready_o  out  queue can accept an entry (not full)
//   enq_pc_i     in   PC of the fetched instruction (word aligned)
//   enq_instr_i  in   fetched instruction word
//   deq_valid_o  out  head entry is valid
//   deq_ready_i  in   ID stage consumes the head entry
//   deq_pc_o     out  head PC            (0 when deq_valid_o = 0)
//   deq_pc4_o    out  head PC + 4        (0 when deq_valid_o = 0)
//   deq_instr_o  out  head instruction   (0 when deq_valid_o = 0)
//   count_o      out  number of occupied entries
//   full_o       out  count_o == DEPTH
//   empty_o      out  count_o == 0
// -----------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int XLEN        = 32,
  parameter int ILEN        = 32,
  parameter int DEPTH       = 4,
  parameter int FALLTHROUGH = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [XLEN-1:0]            enq_pc_i,
  input  logic [ILEN-1:0]            enq_instr_i,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [XLEN-1:0]            deq_pc_o,
  output logic [XLEN-1:0]            deq_pc4_o,
  output logic [ILEN-1:0]            deq_instr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;

  // Storage has no reset: an entry is only ever read after it was written,
  // and the dequeue outputs are forced to zero while nothing is valid.
  logic [XLEN-1:0] pc_mem_reg    [DEPTH];
  logic [ILEN-1:0] instr_mem_reg [DEPTH];

  // ---------------------------------------------------------------------------
  // Status and handshakes
  // ---------------------------------------------------------------------------
  logic empty;
  logic full;
  logic ft_active;   // fall-through path owns the dequeue side this cycle
  logic deq_valid;
  logic enq_fire;
  logic deq_fire;
  logic bypass;      // entry handed straight to ID, never stored
  logic wr_en;
  logic rd_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

  // Ready depends only on registered state, so a full queue refuses an offer
  // even when a dequeue fires in the same cycle.
  assign enq_ready_o = !full;

  assign ft_active = (FALLTHROUGH != 0) && empty;

  // In fall-through mode the valid comes straight from the fetch side; rst_n
  // is folded in so the output takes its reset value while reset is held.
  // Otherwise a flush leaves the current-cycle valid untouched.
  assign deq_valid = ft_active ? (enq_valid_i && !flush_i && rst_n) : !empty;

  assign enq_fire = enq_valid_i && enq_ready_o && !flush_i;
  assign deq_fire = deq_valid   && deq_ready_i && !flush_i;

  // A fall-through entry consumed in the same cycle touches neither the
  // storage nor the pointers/count.
  assign bypass = ft_active && enq_fire && deq_fire;
  assign wr_en  = enq_fire && !bypass;
  assign rd_en  = deq_fire && !bypass;

  // ---------------------------------------------------------------------------
  // Pointer and count next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;

    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so natural overflow wraps DEPTH-1 -> 0.
      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (wr_en && !rd_en) begin
        count_next = count_reg + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage: one write-enable decode per slot
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic slot_we;

      assign slot_we = wr_en && (wr_ptr_reg == PTR_W'(gi));

      always_ff @(posedge clk) begin
        if (slot_we) begin
          pc_mem_reg[gi]    <= enq_pc_i;
          instr_mem_reg[gi] <= enq_instr_i;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Dequeue side
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;

  always_comb begin
    head_pc    = '0;
    head_instr = '0;
    if (deq_valid) begin
      if (ft_active) begin
        head_pc    = enq_pc_i;
        head_instr = enq_instr_i;
      end else begin
        head_pc    = pc_mem_reg[rd_ptr_reg];
        head_instr = instr_mem_reg[rd_ptr_reg];
      end
    end
  end

  assign deq_valid_o = deq_valid;
  assign deq_pc_o    = head_pc;
  assign deq_instr_o = head_instr;
  // Sequential-PC for the decoder; wraps at the top of the address space and
  // stays zero along with the PC when nothing is valid.
  assign deq_pc4_o   = deq_valid ? (head_pc + XLEN'(4)) : '0;

  assign count_o = count_reg;
  assign full_o  = full;
  assign empty_o = empty;

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------
  a_no_enq_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) !(enq_fire && full)
  );

  a_enq_pc_aligned : assert property (
    @(posedge clk) disable iff (!rst_n) !(enq_fire && (enq_pc_i[1:0] != 2'b00))
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Drives one stimulus stream into two queue instances (FALLTHROUGH=0 and 1).
// Each instance has its own scoreboard queue: entries are pushed when the
// model says an enqueue fires and popped/compared when a dequeue fires.
// A table of per-cycle vectors carries the hand-derived count for the
// registered instance; reset sequences are written out by hand.
// -----------------------------------------------------------------------------
module tb_if_fetch_queue;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             enq_valid;
  logic             deq_ready;
  logic [XLEN-1:0]  enq_pc;
  logic [ILEN-1:0]  enq_instr;

  logic             enq_ready [2];
  logic             deq_valid [2];
  logic [XLEN-1:0]  deq_pc    [2];
  logic [XLEN-1:0]  deq_pc4   [2];
  logic [ILEN-1:0]  deq_instr [2];
  logic [CNT_W-1:0] cnt       [2];
  logic             full      [2];
  logic             empty     [2];

  if_fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .FALLTHROUGH(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready[0]),
    .enq_pc_i(enq_pc), .enq_instr_i(enq_instr),
    .deq_valid_o(deq_valid[0]), .deq_ready_i(deq_ready),
    .deq_pc_o(deq_pc[0]), .deq_pc4_o(deq_pc4[0]), .deq_instr_o(deq_instr[0]),
    .count_o(cnt[0]), .full_o(full[0]), .empty_o(empty[0])
  );

  if_fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .FALLTHROUGH(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready[1]),
    .enq_pc_i(enq_pc), .enq_instr_i(enq_instr),
    .deq_valid_o(deq_valid[1]), .deq_ready_i(deq_ready),
    .deq_pc_o(deq_pc[1]), .deq_pc4_o(deq_pc4[1]), .deq_instr_o(deq_instr[1]),
    .count_o(cnt[1]), .full_o(full[1]), .empty_o(empty[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  typedef struct {
    logic            ev;
    logic [XLEN-1:0] pc;
    logic            dr;
    logic            fl;
    int              exp_cnt;   // count after the edge, FALLTHROUGH=0 instance
  } vec_t;

  entry_t q0[$];
  entry_t q1[$];
  vec_t   vecs[$];
  int     tests = 0;
  int     fails = 0;

  function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ev, input logic [XLEN-1:0] pc, input logic dr,
                     input logic fl, input int exp_cnt);
    vec_t v;
    v.ev = ev; v.pc = pc; v.dr = dr; v.fl = fl; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  // Reset-value checks on both instances (inputs must be idle).
  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d count", tag, d), 64'(cnt[d]), 64'd0);
      chk($sformatf("%s dut%0d empty", tag, d), 64'(empty[d]), 64'd1);
      chk($sformatf("%s dut%0d full", tag, d), 64'(full[d]), 64'd0);
      chk($sformatf("%s dut%0d deq_valid", tag, d), 64'(deq_valid[d]), 64'd0);
      chk($sformatf("%s dut%0d enq_ready", tag, d), 64'(enq_ready[d]), 64'd1);
      chk($sformatf("%s dut%0d deq_pc", tag, d), 64'(deq_pc[d]), 64'd0);
    end
  endtask

  // One clock cycle: drive, check the combinational dequeue side against the
  // scoreboards, advance the models, then check the registered status.
  task automatic step(input logic ev, input logic [XLEN-1:0] pc, input logic dr,
                      input logic fl, input int exp_cnt0);
    @(negedge clk);
    enq_valid = ev;
    enq_pc    = pc;
    enq_instr = instr_of(pc);
    deq_ready = dr;
    flush     = fl;
    #1;
    for (int d = 0; d < 2; d++) begin : per_dut
      entry_t q[$];
      entry_t head;
      logic   exp_valid;
      logic   enq_f;
      logic   deq_f;
      logic   byp;
      if (d == 0) q = q0; else q = q1;

      if (q.size() > 0) begin
        exp_valid = 1'b1;
        head      = q[0];
      end else begin
        exp_valid  = (d == 1) ? (ev && !fl) : 1'b0;
        head.pc    = pc;
        head.instr = instr_of(pc);
      end

      chk($sformatf("dut%0d deq_valid pc=%0h", d, pc), 64'(deq_valid[d]), 64'(exp_valid));
      chk($sformatf("dut%0d enq_ready", d), 64'(enq_ready[d]), 64'(q.size() != DEPTH));
      if (exp_valid) begin
        logic [XLEN-1:0] pc4;
        pc4 = head.pc + 32'd4;
        chk($sformatf("dut%0d deq_pc", d), 64'(deq_pc[d]), 64'(head.pc));
        chk($sformatf("dut%0d deq_pc4", d), 64'(deq_pc4[d]), 64'(pc4));
        chk($sformatf("dut%0d deq_instr", d), 64'(deq_instr[d]), 64'(head.instr));
      end else if (d == 0) begin
        chk("dut0 idle deq_pc", 64'(deq_pc[0]), 64'd0);
        chk("dut0 idle deq_instr", 64'(deq_instr[0]), 64'd0);
      end

      enq_f = ev && (q.size() < DEPTH) && !fl;
      deq_f = exp_valid && dr && !fl;
      byp   = deq_f && (q.size() == 0);
      if (fl) begin
        q.delete();
      end else begin
        if (deq_f) begin
          $display("[TB] dut%0d dequeue pc=%08h instr=%08h%s", d, head.pc, head.instr,
                   byp ? " (pass-through)" : "");
          if (!byp) void'(q.pop_front());
        end
        if (enq_f && !byp) begin
          entry_t e;
          e.pc    = pc;
          e.instr = instr_of(pc);
          q.push_back(e);
        end
      end
      if (d == 0) q0 = q; else q1 = q;
    end
    @(posedge clk);
    #1;
    chk("dut0 count vs table", 64'(cnt[0]), 64'(exp_cnt0));
    for (int d = 0; d < 2; d++) begin
      int sz;
      sz = (d == 0) ? q0.size() : q1.size();
      chk($sformatf("dut%0d count", d), 64'(cnt[d]), 64'(sz));
      chk($sformatf("dut%0d full", d), 64'(full[d]), 64'(sz == DEPTH));
      chk($sformatf("dut%0d empty", d), 64'(empty[d]), 64'(sz == 0));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_pc    = '0;
    enq_instr = '0;

    // Fill to full, then a refused fifth offer.
    add(1, 32'h0000_0000, 0, 0, 1);
    add(1, 32'h0000_0004, 0, 0, 2);
    add(1, 32'h0000_0008, 0, 0, 3);
    add(1, 32'h0000_000C, 0, 0, 4);
    add(1, 32'h0000_0010, 0, 0, 4);
    // Drain.
    add(0, 32'h0, 1, 0, 3);
    add(0, 32'h0, 1, 0, 2);
    add(0, 32'h0, 1, 0, 1);
    add(0, 32'h0, 1, 0, 0);
    add(0, 32'h0, 0, 0, 0);
    // Build to two (pass-through on the fall-through instance), then
    // eight cycles of simultaneous enqueue/dequeue.
    add(1, 32'h0000_0020, 1, 0, 1);
    add(1, 32'h0000_0024, 0, 0, 2);
    for (int i = 0; i < 8; i++) add(1, 32'h0000_0400 + 32'(4 * i), 1, 0, 2);
    // Fill, then flush with a concurrent enqueue of 0x40 and a dequeue.
    add(1, 32'h0000_0500, 0, 0, 3);
    add(1, 32'h0000_0504, 0, 0, 4);
    add(1, 32'h0000_0040, 1, 1, 0);
    add(0, 32'h0, 0, 0, 0);
    add(1, 32'h0000_0080, 0, 0, 1);
    add(0, 32'h0, 1, 0, 0);
    // Flush held for two cycles.
    add(1, 32'h0000_0084, 0, 0, 1);
    add(1, 32'h0000_0088, 0, 1, 0);
    add(1, 32'h0000_008C, 1, 1, 0);
    add(0, 32'h0, 0, 0, 0);
    // Fall-through cases at 0x100.
    add(1, 32'h0000_0100, 1, 0, 1);
    add(0, 32'h0, 1, 0, 0);
    add(1, 32'h0000_0100, 0, 0, 1);
    add(0, 32'h0, 0, 0, 1);
    add(0, 32'h0, 1, 0, 0);
    // PC+4 wrap at the top of the address space.
    add(1, 32'hFFFF_FFFC, 0, 0, 1);
    add(0, 32'h0, 1, 0, 0);
    // Flush on an empty queue with an offer and a ready ID stage.
    add(1, 32'h0000_0090, 1, 1, 0);
    add(0, 32'h0, 0, 0, 0);

    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ev, vecs[i].pc, vecs[i].dr, vecs[i].fl, vecs[i].exp_cnt);
    end

    // Reset asserted mid-fill, checked before the next clock edge.
    step(1, 32'h0000_0200, 0, 0, 1);
    step(1, 32'h0000_0204, 0, 0, 2);
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    q1.delete();

    // Operation resumes after reset release; old entries are gone.
    step(1, 32'h0000_0300, 0, 0, 1);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
